// File: rtl/shift_encoding_core_pkg.sv
// Purpose: shared widths and the rotation-amount helper for the shift encoding core.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package shift_encoding_core_pkg;

    localparam int SEG_W  = 10;
    localparam int NSEG   = 8;
    localparam int DATA_W = 80;
    localparam int KEY_W  = 64;
    localparam int ROT_W  = 4;

    // Key byte reduced modulo the segment width gives the rotation amount, 0..9.
    function automatic logic [ROT_W-1:0] rot_amount(input logic [7:0] key_byte);
        return ROT_W'(key_byte % 8'd10);
    endfunction

endpackage

// File: rtl/shift_encoding_core_seg_rotator.sv
// Purpose: rotate one 10-bit segment left (encode) or right (decode) by key byte mod 10.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module seg_rotator
    import shift_encoding_core_pkg::*;
(
    input  logic [SEG_W-1:0] seg_in,
    input  logic [7:0]       key_byte,
    input  logic             decode,
    output logic [SEG_W-1:0] seg_out
);

    logic [ROT_W-1:0]   rot;
    logic [2*SEG_W-1:0] dbl;

    assign rot = rot_amount(key_byte);
    assign dbl = {seg_in, seg_in};

    // Doubling the segment turns a rotation into a plain shift of a 20-bit word;
    // the upper half after a left shift, or the lower half after a right shift,
    // is the rotated segment.
    always_comb begin
        seg_out = '0;
        if (decode)
            seg_out = SEG_W'(dbl >> rot);
        else
            seg_out = SEG_W'((dbl << rot) >> SEG_W);
    end

endmodule

// File: rtl/shift_encoding_core.sv
// Purpose: per-segment keyed rotation of an 80-bit block (encode = rotate left, decode = rotate right).
// Latency: one cycle; result and out_valid appear after the edge that sampled in_valid.
// Backpressure: none; accepts one block per cycle, result holds while in_valid is low.
module shift_encoding_core
    import shift_encoding_core_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              decode,
    input  logic [0:DATA_W-1] data_in,
    input  logic [0:KEY_W-1]  final_key,
    output logic [0:DATA_W-1] data_out,
    output logic              out_valid
);

    logic [0:DATA_W-1] result;

    // Segment i occupies bits [10i:10i+9] and uses key byte i; bit 10i is the
    // segment MSB, so the ascending slice lands MSB-first on each rotator.
    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        seg_rotator u_rot (
            .seg_in   (data_in[SEG_W*g +: SEG_W]),
            .key_byte (final_key[8*g +: 8]),
            .decode   (decode),
            .seg_out  (result[SEG_W*g +: SEG_W])
        );
    end

    // Output register: capture on in_valid, hold otherwise; reset clears at once,
    // which also discards anything sampled while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                data_out <= result;
        end
    end

endmodule

// File: tb/tb_shift_encoding_core.sv
module tb_shift_encoding_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        decode = 1'b0;
    logic [0:79] data_in = '0;
    logic [0:63] final_key = '0;
    logic [0:79] data_out;
    logic        out_valid;

    int tests_run = 0;
    int tests_failed = 0;

    shift_encoding_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .decode    (decode),
        .data_in   (data_in),
        .final_key (final_key),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: output bit j of segment s is input bit (j+r) mod 10 for a left
    // rotation, (j-r) mod 10 for a right rotation, counting from the segment MSB.
    function automatic logic [0:79] model(input logic [0:79] d, input logic [0:63] k, input logic dec);
        logic [0:79] o;
        int unsigned kb;
        int r, src;
        o = '0;
        for (int s = 0; s < 8; s++) begin
            kb = k[8*s +: 8];
            r  = int'(kb % 10);
            for (int j = 0; j < 10; j++) begin
                src = dec ? (j - r + 10) % 10 : (j + r) % 10;
                o[10*s + j] = d[10*s + src];
            end
        end
        return o;
    endfunction

    // One isolated transaction; returns the captured data_out.
    task automatic send(input logic [0:79] d, input logic [0:63] k, input logic dec,
                        input string tag, output logic [0:79] got);
        @(negedge clk);
        data_in = d; final_key = k; decode = dec; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        data_in = 80'($urandom());
        check({tag, "_vld"}, 80'(out_valid), 80'd1);
        check(tag, data_out, model(d, k, dec));
        got = data_out;
    endtask

    logic [0:79] got, enc, d, seg0;
    logic [0:63] k;
    logic [0:79] bd [4];
    logic [0:63] bk [4];
    logic        bm [4];

    initial begin
        // Reset state
        #2;
        check("rst_data", data_out, 80'h0);
        check("rst_vld", 80'(out_valid), 80'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Known vectors
        send(80'h78554abc478acbdef789, 64'h0102030405060708, 1'b0, "enc_vec", got);
        check("enc_vec_const", got, 80'hF09515F4715C74BBDDE2);
        send(80'hF09515F4715C74BBDDE2, 64'h0102030405060708, 1'b1, "dec_vec", got);
        check("dec_vec_const", got, 80'h78554abc478acbdef789);

        // Hold with in_valid low
        repeat (3) @(negedge clk);
        check("hold_vld", 80'(out_valid), 80'd0);
        check("hold_data", data_out, 80'h78554abc478acbdef789);

        // Identity keys in both modes
        for (int i = 0; i < 4; i++) begin
            d = {$urandom(), $urandom(), 16'($urandom())};
            send(d, 64'h000A141E28323C46, i[0], "ident", got);
            check("ident_const", got, d);
        end

        // Mod-10 wrap with 0xFF keys
        send(80'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0, "wrap_zero", got);
        check("wrap_zero_const", got, 80'h0);
        seg0 = '0;
        seg0[0:9] = 10'b1000000000;
        send(seg0, 64'hFFFFFFFFFFFFFFFF, 1'b0, "wrap_seg0", got);
        check("wrap_seg0_const", 80'(got[0:9]), 80'(10'b0000010000));

        // Back-to-back stream
        for (int i = 0; i < 4; i++) begin
            bd[i] = {$urandom(), $urandom(), 16'($urandom())};
            bk[i] = {$urandom(), $urandom()};
            bm[i] = 1'($urandom());
        end
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("b2b_vld", 80'(out_valid), 80'd1);
                check("b2b_data", data_out, model(bd[i-1], bk[i-1], bm[i-1]));
            end
            if (i < 4) begin
                data_in = bd[i]; final_key = bk[i]; decode = bm[i]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end

        // Reset mid-stream: asserted between edges, input in flight discarded
        @(negedge clk);
        data_in = {$urandom(), $urandom(), 16'($urandom())};
        final_key = {$urandom(), $urandom()}; decode = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_data", data_out, 80'h0);
        check("rst_async_vld", 80'(out_valid), 80'd0);
        @(negedge clk);
        check("rst_hold_data", data_out, 80'h0);
        check("rst_hold_vld", 80'(out_valid), 80'd0);
        in_valid = 1'b0;
        rst = 1'b0;

        // Back-to-back after release
        for (int i = 0; i < 4; i++) begin
            bd[i] = {$urandom(), $urandom(), 16'($urandom())};
            bk[i] = {$urandom(), $urandom()};
            bm[i] = 1'($urandom());
        end
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("post_rst_vld", 80'(out_valid), 80'd1);
                check("post_rst_data", data_out, model(bd[i-1], bk[i-1], bm[i-1]));
            end
            if (i < 4) begin
                data_in = bd[i]; final_key = bk[i]; decode = bm[i]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end

        // Random round trips
        for (int i = 0; i < 1000; i++) begin
            d = {$urandom(), $urandom(), 16'($urandom())};
            k = {$urandom(), $urandom()};
            send(d, k, 1'b0, "rand_enc", enc);
            send(enc, k, 1'b1, "rand_dec", got);
            check("rand_roundtrip", got, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
